// File: rtl/word_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpacker_if
//  Description : Handshake bundle for word_unpacker. The word side uses
//                in_valid/in_ready/data_in. The chunk side uses
//                out_valid/out_ready/data_out with last, chunk_idx and busy
//                as sideband signals.
//                slave  : the unpacker itself
//                master : the environment (word source and chunk consumer)
//  Revision    : 1.0  initial release
// ============================================================================
interface word_unpacker_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    localparam int c_NCHUNK = IN_W / OUT_W;
    localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     data_in;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    data_out;
    logic                last;
    logic [c_CW-1:0]     chunk_idx;
    logic                busy;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, last, chunk_idx, busy
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, last, chunk_idx, busy
    );
endinterface
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpacker
//  Description : Width-down converter. It takes one IN_W-bit word through a
//                valid/ready handshake and emits IN_W/OUT_W chunks of
//                OUT_W bits, one chunk per cycle when the consumer is ready.
//                When the last chunk of a word is accepted in the same cycle
//                that a new word arrives, the new word loads with no bubble.
//                Optional macro UNPACK_MSB_FIRST_EN: emit the most
//                significant chunk first (default: least significant first).
//  Revision    : 1.0  initial release
// ============================================================================
module word_unpacker #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  wire              Clk,
    input  wire              Reset,
    word_unpacker_if.slave   bus
);
    localparam int c_NCHUNK = IN_W / OUT_W;
    localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_CW-1:0] c_LAST_IDX = c_CW'(c_NCHUNK - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_W-1:0]    r_sbuf;
    logic [IN_W-1:0]    w_sbuf_nxt;
    logic [IN_W-1:0]    w_sbuf_shifted;
    logic [c_CW-1:0]    r_cnt;
    logic [c_CW-1:0]    w_cnt_nxt;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;

    // The chunk on data_out always comes from the register end that
    // shifts out first, so the output is a plain register slice.
`ifdef UNPACK_MSB_FIRST_EN
    assign w_sbuf_shifted = r_sbuf << OUT_W;
    assign bus.data_out   = r_sbuf[IN_W-1 -: OUT_W];
`else
    assign w_sbuf_shifted = r_sbuf >> OUT_W;
    assign bus.data_out   = r_sbuf[OUT_W-1:0];
`endif

    assign w_last = (r_cnt == c_LAST_IDX);

    // State, shift buffer and chunk counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_sbuf  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sbuf  <= w_sbuf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and handshake decode. in_ready is derived from the
    // state and out_ready only, so no combinational path exists from
    // in_valid to in_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_sbuf_nxt  = r_sbuf;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_sbuf_nxt  = bus.data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready & w_last;
                if (bus.out_ready) begin
                    if (!w_last) begin
                        w_sbuf_nxt = w_sbuf_shifted;
                        w_cnt_nxt  = r_cnt + c_CNT_ONE;
                    end else if (bus.in_valid) begin
                        // Last chunk leaves while the next word arrives.
                        w_sbuf_nxt = bus.data_in;
                        w_cnt_nxt  = '0;
                    end else begin
                        // Clear the buffer so an idle unpacker shows zero.
                        w_sbuf_nxt  = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_out_valid;
    assign bus.last      = w_out_valid & w_last;
    assign bus.chunk_idx = r_cnt;

endmodule
`default_nettype wire
